// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative one-bit-per-clock MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Operands are reduced to unsigned magnitudes at start; signs are reapplied in the FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_dz;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_hi;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // op[0] selects the signed variants; op[1] selects divide.
    assign w_sa    = op[0] & operand_a[WIDTH-1];
    assign w_sb    = op[0] & operand_b[WIDTH-1];
    assign w_abs_a = w_sa ? (~operand_a + 1'b1) : operand_a;
    assign w_abs_b = w_sb ? (~operand_b + 1'b1) : operand_b;

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: {remainder, dividend/quotient} shifts left, quotient bits enter at the LSB.
    assign w_div_hi    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_trial = w_div_hi - {1'b0, r_mag_b};
    assign w_div_next  = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_fix = (r_op[0] && (r_sa ^ r_sb)) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = (r_op[0] && (r_sa ^ r_sb)) ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem_fix  = (r_op[0] && r_sa) ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dz    <= 1'b0;
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_sa    <= w_sa;
                        r_sb    <= w_sb;
                        r_mag_a <= w_abs_a;
                        r_mag_b <= w_abs_b;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        if (op[1] && (operand_b == '0)) begin
                            // Zero divisor skips iteration; result is preloaded as {dividend, all-ones}.
                            r_dz    <= 1'b1;
                            r_acc   <= {operand_a, {WIDTH{1'b1}}};
                            r_state <= S_FIX;
                        end else begin
                            r_dz    <= 1'b0;
                            r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_hi <= r_acc[2*WIDTH-1:WIDTH];
                        r_lo <= r_acc[WIDTH-1:0];
                    end else if (r_op[1]) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_dbz   <= r_dz;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_bad;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues an op on the next edge (E0) and returns the number of edges after E0 until done is seen.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (hi !== 32'h0)  begin n_bad++; $display("FAIL reset_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0)  begin n_bad++; $display("FAIL reset_lo got %h want 00000000", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    endtask

    task automatic test_multu_max;
        int n;
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL multu_latency got %0d want 33", n); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_max_hi got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_max_lo got %h want 00000001", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL multu_busy_at_done got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int n;
        do_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, n);
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_neg_lo got %h want fffffff1", lo); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL mult_dbz got %b want 0", div_by_zero); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done_before_issue got %b want 1", done); end
        do_op(OP_MULTU, 32'd7, 32'd6, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL b2b_latency got %0d want 33", n); end
        n_cmp++; if (hi !== 32'd0)  begin n_bad++; $display("FAIL b2b_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'd42) begin n_bad++; $display("FAIL b2b_lo got %0d want 42", lo); end
    endtask

    task automatic test_divide;
        int n;
        do_op(OP_DIVU, 32'd100, 32'd7, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL divu_latency got %0d want 33", n); end
        n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %0d want 14", lo); end
        n_cmp++; if (hi !== 32'd2)  begin n_bad++; $display("FAIL divu_hi got %0d want 2", hi); end
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n);
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL div_ovf_dbz got %b want 0", div_by_zero); end
    endtask

    task automatic test_div_by_zero;
        int n;
        do_op(OP_DIV, 32'd55, 32'd0, n);
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL dz_latency got %0d want 1", n); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_bad++; $display("FAIL dz_flag got %b want 1", div_by_zero); end
        n_cmp++; if (hi !== 32'd55) begin n_bad++; $display("FAIL dz_hi got %0d want 55", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_lo got %h want ffffffff", lo); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL dz_busy got %b want 0", busy); end
        @(posedge clk); #1;
        n_cmp++; if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL dz_flag_clear got %b want 0", div_by_zero); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dz_done_clear got %b want 0", done); end
    endtask

    task automatic test_start_while_busy;
        int first_done;
        int pulses;
        logic [31:0] hi_s;
        logic [31:0] lo_s;
        first_done = 0;
        pulses = 0;
        hi_s = 32'hDEAD_BEEF;
        lo_s = 32'hDEAD_BEEF;
        start = 1'b1; op = OP_MULTU; operand_a = 32'd3; operand_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            if (e == 10) begin
                start = 1'b1; op = OP_DIVU; operand_a = 32'd9; operand_b = 32'd3;
            end
            @(posedge clk); #1;
            if (e == 10) start = 1'b0;
            if (e == 5) begin
                operand_a = 32'd9; operand_b = 32'd3;
            end
            if (done) begin
                pulses++;
                if (first_done == 0) begin
                    first_done = e;
                    hi_s = hi;
                    lo_s = lo;
                end
            end
        end
        n_cmp++; if (first_done !== 33) begin n_bad++; $display("FAIL ignore_latency got %0d want 33", first_done); end
        n_cmp++; if (lo_s !== 32'd12) begin n_bad++; $display("FAIL ignore_lo got %0d want 12", lo_s); end
        n_cmp++; if (hi_s !== 32'd0)  begin n_bad++; $display("FAIL ignore_hi got %0d want 0", hi_s); end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid_op;
        int n;
        int pulses;
        pulses = 0;
        start = 1'b1; op = OP_MULT; operand_a = 32'hFFFF_FFFD; operand_b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL midrst_hi got %h want 00000000", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_bad++; $display("FAIL midrst_lo got %h want 00000000", lo); end
        for (int e = 0; e < 40; e++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_no_done got %0d want 0", pulses); end
        do_op(OP_MULTU, 32'd2, 32'd2, n);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL postrst_latency got %0d want 33", n); end
        n_cmp++; if (lo !== 32'd4) begin n_bad++; $display("FAIL postrst_lo got %0d want 4", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL postrst_hi got %0d want 0", hi); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        operand_a = '0;
        operand_b = '0;
        @(negedge clk);
        test_reset;
        test_multu_max;
        test_back_to_back;
        test_divide;
        test_div_by_zero;
        test_start_while_busy;
        test_reset_mid_op;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
